// File: rtl/rv32_pkg.sv
// Shared RV32I front-end definitions.
//   XLEN             : architectural register / address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0)
//   fetch_entry_t    : one buffered instruction together with its address
//   align_word()     : forces an address onto a 4-byte boundary
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // RV32I has no compressed instructions, so the two low address bits are
  // always zero for a legal fetch address.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Bus bundle between the fetch stage and its neighbours.
//   Instruction memory request : imem_req_valid/imem_req_ready/imem_req_addr
//   Instruction memory response: imem_rsp_valid/imem_rsp_data (never stalled)
//   Decode handshake           : inst_valid/inst_ready/inst/inst_pc
//   Redirect from execute      : redirect/redirect_pc
// master = the fetch stage, slave = memory + decode + redirect source.
interface fetch_buffer_if;
  import rv32_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    output redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used twice by the fetch stage (PC tag queue and
// instruction buffer).
//   clk, reset    : clock, synchronous active-high reset
//   flush_i       : synchronous clear, wins over push/pop
//   push_i/_data_i: write one entry (accepted when not full, or full and
//                   popping in the same cycle)
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry (no bypass from push)
//   count_o       : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en;
  logic             pop_en;

  always_comb begin
    pop_en  = pop_i && (count_q != '0);
    // A full FIFO can still take a write when the head leaves this cycle:
    // the slot being written is the one being freed.
    push_en = push_i && ((count_q != CW'(DEPTH)) || pop_en);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_en && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// RV32I instruction fetch stage.
// Owns the fetch PC, issues in-order word requests to instruction memory,
// tags each request with its PC, and buffers returned words for decode.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : fetch_buffer_if.master
//                - imem_req_*  : request channel (valid/ready, word address)
//                - imem_rsp_*  : response channel, in order, never stalled
//                - inst_*      : instruction + PC towards decode
//                - redirect*   : flush and restart at a new address
// Parameters: RESET_PC (first fetch address), DEPTH (buffer entries and
// maximum outstanding requests, power of two 2..8).
module fetch_buffer
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  fetch_buffer_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic            req_valid;
  logic            req_fire;
  logic            rsp_keep;
  logic            inst_pop;
  logic [CW:0]     occupancy;

  logic [XLEN-1:0] tag_head;
  logic [CW-1:0]   unused_tag_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic [EW-1:0]   buf_head;
  logic [CW-1:0]   buf_count;

  // Responses are only kept when no stale responses are still owed from
  // before a redirect; a redirect in the same cycle also discards it.
  assign rsp_keep = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect;
  assign inst_pop = bus.inst_valid && bus.inst_ready && !bus.redirect;

  // Credit check: every issued request must have a buffer slot waiting for
  // its response. A slot freed by a pop this cycle can be reused, because
  // the response to a request accepted now arrives no earlier than next
  // cycle; this keeps a 1-cycle memory streaming one word per cycle.
  assign occupancy = {1'b0, outstanding_q} + {1'b0, buf_count}
                   - {{CW{1'b0}}, inst_pop};
  assign req_valid = !reset && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;

  // PC tags of requests still awaiting a kept response, in issue order.
  // Requests issued before a redirect are never tagged here again after the
  // flush, and their responses are dropped without popping.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.redirect),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (rsp_keep),
    .head_o      (tag_head),
    .count_o     (unused_tag_count)
  );

  always_comb begin
    push_entry.pc   = tag_head;
    push_entry.inst = bus.imem_rsp_data;
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.redirect),
    .push_i      (rsp_keep),
    .push_data_i (push_entry),
    .pop_i       (inst_pop),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  assign head_entry     = buf_head;
  assign bus.inst_valid = (buf_count != '0);
  // Empty-buffer outputs are forced to zero so decode never sees
  // uninitialised storage.
  assign bus.inst       = bus.inst_valid ? head_entry.inst : '0;
  assign bus.inst_pc    = bus.inst_valid ? head_entry.pc   : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (bus.redirect) begin
      fetch_pc_d    = align_word(bus.redirect_pc);
      // Everything still in flight after this cycle is stale.
      outstanding_d = outstanding_q - CW'(bus.imem_rsp_valid);
      drop_cnt_d    = outstanding_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        // Natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule
